// File: rtl/exec_unit_if.sv
// Issue interface between the register manager's output FIFO and the execution unit.
// The master drives one decoded operation; the slave answers with ok_o.
interface exec_unit_if #(
  parameter int unsigned xlen = 32
);
  logic            valid_i;
  logic            ok_o;
  logic [1:0]      unit_i;
  logic [2:0]      sub_unit_i;
  logic [3:0]      sel_i;
  logic [xlen-1:0] rs1_i;
  logic [xlen-1:0] rs2_i;
  logic [4:0]      rd_i;
  logic [xlen-1:0] jal_res_i;

  modport master (
    output valid_i, unit_i, sub_unit_i, sel_i, rs1_i, rs2_i, rd_i, jal_res_i,
    input  ok_o
  );

  modport slave (
    input  valid_i, unit_i, sub_unit_i, sel_i, rs1_i, rs2_i, rd_i, jal_res_i,
    output ok_o
  );
endinterface

// File: rtl/exec_unit.sv
// Execution unit: single-cycle ALU/branch, iterative 32-cycle shift-add multiplier,
// registered writeback and branch-resolution strobes.
module exec_unit #(
  parameter int unsigned xlen       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  exec_unit_if.slave      issue,
  input  logic            flush_i,
  output logic [xlen-1:0] res_data,
  output logic [4:0]      res_adr,
  output logic            res_v,
  output logic            br_v_o,
  output logic            br_taken_o,
  output logic            unsupported_o
);

  localparam int unsigned CW = $clog2(MUL_CYCLES);
  localparam int unsigned PW = 2 * xlen;

  localparam logic [1:0] UNIT_ALU  = 2'd0;
  localparam logic [1:0] UNIT_MUL  = 2'd2;
  localparam logic [2:0] SUB_PC    = 3'd0;
  localparam logic [2:0] SUB_BR    = 3'd1;
  localparam logic [2:0] SUB_ARITH = 3'd2;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [xlen-1:0] op_a_q, op_a_d;
  logic [xlen-1:0] op_b_q, op_b_d;
  logic [3:0]      sel_q, sel_d;
  logic [4:0]      rd_q, rd_d;
  logic            ok_q, ok_d;

  logic [xlen-1:0] res_data_d;
  logic [4:0]      res_adr_d;
  logic            res_v_d, br_v_d, br_taken_d, unsupported_d;

  logic            accept;
  logic [4:0]      shamt;
  logic [xlen-1:0] arith_res, pc_res, mul_res;
  logic            taken;
  logic [xlen:0]   step_sum;
  logic [PW-1:0]   prod_step;
  logic [xlen-1:0] prod_hi, prod_lo, corr_a, corr_b;

  assign issue.ok_o = ok_q;
  // A flush drops whatever is offered in the same cycle.
  assign accept     = issue.valid_i & ok_q & ~flush_i;
  assign shamt      = issue.rs2_i[4:0];

  always_comb begin
    arith_res = '0;
    unique case (issue.sel_i)
      4'd0:    arith_res = issue.rs1_i + issue.rs2_i;
      4'd1:    arith_res = issue.rs1_i - issue.rs2_i;
      4'd2:    arith_res = issue.rs1_i << shamt;
      4'd3:    arith_res = xlen'($signed(issue.rs1_i) < $signed(issue.rs2_i));
      4'd4:    arith_res = xlen'(issue.rs1_i < issue.rs2_i);
      4'd5:    arith_res = issue.rs1_i ^ issue.rs2_i;
      4'd6:    arith_res = issue.rs1_i >> shamt;
      4'd7:    arith_res = xlen'($signed(issue.rs1_i) >>> shamt);
      4'd8:    arith_res = issue.rs1_i | issue.rs2_i;
      4'd9:    arith_res = issue.rs1_i & issue.rs2_i;
      default: arith_res = '0;
    endcase
  end

  always_comb begin
    pc_res = '0;
    unique case (issue.sel_i)
      4'd0:       pc_res = issue.rs2_i;
      4'd1:       pc_res = issue.rs1_i + issue.rs2_i;
      4'd2, 4'd3: pc_res = issue.jal_res_i;
      default:    pc_res = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    unique case (issue.sel_i)
      4'd0:    taken = (issue.rs1_i == issue.rs2_i);
      4'd1:    taken = (issue.rs1_i != issue.rs2_i);
      4'd4:    taken = ($signed(issue.rs1_i) <  $signed(issue.rs2_i));
      4'd5:    taken = ($signed(issue.rs1_i) >= $signed(issue.rs2_i));
      4'd6:    taken = (issue.rs1_i <  issue.rs2_i);
      4'd7:    taken = (issue.rs1_i >= issue.rs2_i);
      default: taken = 1'b0;
    endcase
  end

  // One shift-add step: low half holds the remaining multiplier bits, high half the partial sum.
  assign step_sum  = {1'b0, prod_q[PW-1:xlen]} + (prod_q[0] ? {1'b0, op_a_q} : '0);
  assign prod_step = {step_sum, prod_q[xlen-1:1]};
  assign prod_hi   = prod_step[PW-1:xlen];
  assign prod_lo   = prod_step[xlen-1:0];
  assign corr_a    = op_a_q[xlen-1] ? op_b_q : '0;
  assign corr_b    = op_b_q[xlen-1] ? op_a_q : '0;

  // Signed high products are recovered from the unsigned product by subtracting the sign corrections.
  always_comb begin
    mul_res = '0;
    unique case (sel_q)
      4'd0:    mul_res = prod_lo;
      4'd1:    mul_res = prod_hi - corr_a - corr_b;
      4'd2:    mul_res = prod_hi - corr_a;
      4'd3:    mul_res = prod_hi;
      default: mul_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      prod_q        <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      sel_q         <= '0;
      rd_q          <= '0;
      ok_q          <= 1'b1;
      res_data      <= '0;
      res_adr       <= '0;
      res_v         <= 1'b0;
      br_v_o        <= 1'b0;
      br_taken_o    <= 1'b0;
      unsupported_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prod_q        <= prod_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      sel_q         <= sel_d;
      rd_q          <= rd_d;
      ok_q          <= ok_d;
      res_data      <= res_data_d;
      res_adr       <= res_adr_d;
      res_v         <= res_v_d;
      br_v_o        <= br_v_d;
      br_taken_o    <= br_taken_d;
      unsupported_o <= unsupported_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    prod_d        = prod_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    sel_d         = sel_q;
    rd_d          = rd_q;
    res_data_d    = res_data;
    res_adr_d     = res_adr;
    res_v_d       = 1'b0;
    br_v_d        = 1'b0;
    br_taken_d    = 1'b0;
    unsupported_d = 1'b0;

    unique case (state_q)
      MUL: begin
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          prod_d = prod_step;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(MUL_CYCLES - 1)) begin
            state_d    = DONE;
            cnt_d      = '0;
            res_data_d = mul_res;
            res_adr_d  = rd_q;
            res_v_d    = (rd_q != 5'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Only reachable outside MUL, since ok is low while multiplying.
    if (accept) begin
      unique case (issue.unit_i)
        UNIT_ALU: begin
          unique case (issue.sub_unit_i)
            SUB_PC: begin
              res_data_d = pc_res;
              res_adr_d  = issue.rd_i;
              res_v_d    = (issue.rd_i != 5'd0);
            end
            SUB_BR: begin
              br_v_d     = 1'b1;
              br_taken_d = taken;
            end
            SUB_ARITH: begin
              res_data_d = arith_res;
              res_adr_d  = issue.rd_i;
              res_v_d    = (issue.rd_i != 5'd0);
            end
            default: unsupported_d = 1'b1;
          endcase
        end
        UNIT_MUL: begin
          state_d = MUL;
          cnt_d   = '0;
          op_a_d  = issue.rs1_i;
          op_b_d  = issue.rs2_i;
          sel_d   = issue.sel_i;
          rd_d    = issue.rd_i;
          prod_d  = {{xlen{1'b0}}, issue.rs2_i};
        end
        default: unsupported_d = 1'b1;
      endcase
    end

    ok_d = (state_d != MUL);
  end

endmodule
